// File: rtl/cache_miss_controller.sv
// cache_miss_controller
// Miss-handling control stage for a 2-way set-associative cache. It sits
// behind the hit encoder, keeps per-set valid/dirty/LRU state, picks a victim
// on a miss, sequences the beat-counted writeback and refill handshakes with
// memory, and drives the data/tag array strobes and the CPU completion pulse.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   cpu_req/cpu_we    CPU request (held until cpu_ready) and store flag
//   cpu_index         set index of the request
//   miss, way_f       hit-encoder result; sampled only when a request is accepted
//   cpu_ready         one-cycle completion pulse
//   busy              controller is not idle
//   wb_req            writeback in progress
//   refill_req        refill in progress
//   mem_ack           one pulse per transferred beat
//   beat_idx          current beat within the line
//   act_way           way being accessed, written back or refilled
//   array_we          data array word write strobe
//   tag_we            tag write strobe (act_way at the latched index)
module cache_miss_controller #(
  parameter int INDEX_W = 4,
  parameter int BEATS   = 4,
  parameter int BEAT_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [INDEX_W-1:0] cpu_index,
  input  logic               miss,
  input  logic               way_f,
  output logic               cpu_ready,
  output logic               busy,
  output logic               wb_req,
  output logic               refill_req,
  input  logic               mem_ack,
  output logic [BEAT_W-1:0]  beat_idx,
  output logic               act_way,
  output logic               array_we,
  output logic               tag_we
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0][1:0] valid_q;
  logic [SETS-1:0][1:0] dirty_q;
  logic [SETS-1:0]      lru_q;     // way to evict next when both ways are valid

  logic [INDEX_W-1:0] idx_q;
  logic               we_q;
  logic               act_way_q;
  logic [BEAT_W-1:0]  beat_q;

  logic accept;       // request taken this cycle
  logic victim;
  logic victim_wb;    // victim holds modified data and must be written back
  logic last_beat;

  assign accept    = (state_q == IDLE) && cpu_req;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Fill invalid ways first (way 0 before way 1), otherwise follow LRU.
  always_comb begin
    victim = lru_q[cpu_index];
    if (!valid_q[cpu_index][0])      victim = 1'b0;
    else if (!valid_q[cpu_index][1]) victim = 1'b1;
    victim_wb = valid_q[cpu_index][victim] && dirty_q[cpu_index][victim];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (!miss)          state_d = RESPOND;
          else if (victim_wb) state_d = WRITEBACK;
          else                state_d = REFILL;
        end
      end
      WRITEBACK: if (mem_ack && last_beat) state_d = REFILL;
      REFILL:    if (mem_ack && last_beat) state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath / bookkeeping state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      lru_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      act_way_q <= 1'b0;
      beat_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            idx_q  <= cpu_index;
            we_q   <= cpu_we;
            beat_q <= '0;
            if (!miss) begin
              act_way_q        <= way_f;
              lru_q[cpu_index] <= ~way_f;
              if (cpu_we) dirty_q[cpu_index][way_f] <= 1'b1;
            end else begin
              act_way_q <= victim;
            end
          end
        end
        WRITEBACK: begin
          // Counter wraps to 0 on the last beat, ready for the refill.
          if (mem_ack) beat_q <= beat_q + 1'b1;
        end
        REFILL: begin
          if (mem_ack) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              valid_q[idx_q][act_way_q] <= 1'b1;
              dirty_q[idx_q][act_way_q] <= we_q;
              lru_q[idx_q]              <= ~act_way_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic. Strobes are masked by rst so an aborted transfer never
  // writes the arrays in the reset cycle.
  always_comb begin
    cpu_ready  = (state_q == RESPOND);
    busy       = (state_q != IDLE);
    wb_req     = (state_q == WRITEBACK);
    refill_req = (state_q == REFILL);
    beat_idx   = beat_q;
    act_way    = act_way_q;
    array_we   = 1'b0;
    tag_we     = 1'b0;
    if (!rst) begin
      // A hit is serviced in the accept cycle, so the way comes straight
      // from the hit encoder rather than the latched copy.
      if (accept && !miss) begin
        act_way  = way_f;
        array_we = cpu_we;
      end
      if ((state_q == REFILL) && mem_ack) begin
        array_we = 1'b1;
        tag_we   = last_beat;
      end
    end
  end

endmodule

// File: tb/tb_cache_miss_controller.sv
module tb_cache_miss_controller;
  localparam int IW    = 4;
  localparam int BEATS = 4;
  localparam int BW    = 2;
  localparam int SETS  = 1 << IW;

  logic          clk, rst, cpu_req, cpu_we, miss, way_f, mem_ack;
  logic [IW-1:0] cpu_index;
  logic          cpu_ready, busy, wb_req, refill_req, act_way, array_we, tag_we;
  logic [BW-1:0] beat_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: per-set line bookkeeping at transaction level.
  bit m_valid [SETS][2];
  bit m_dirty [SETS][2];
  bit m_lru   [SETS];

  cache_miss_controller #(.INDEX_W(IW), .BEATS(BEATS), .BEAT_W(BW)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_index(cpu_index), .miss(miss), .way_f(way_f),
    .cpu_ready(cpu_ready), .busy(busy), .wb_req(wb_req),
    .refill_req(refill_req), .mem_ack(mem_ack), .beat_idx(beat_idx),
    .act_way(act_way), .array_we(array_we), .tag_we(tag_we)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = '{0, 0};
      m_dirty[s] = '{0, 0};
      m_lru[s]   = 0;
    end
  endfunction

  // One complete CPU access: request, optional writeback/refill, response.
  // gaps inserts random idle cycles between acks and toggles cpu_req there.
  task automatic access(input int idx, input bit we, input bit m, input bit wf,
                        input bit gaps, input string nm);
    bit v, wb, is_rf;
    int xfers;
    logic [BW-1:0] eb;
    v  = wf;
    wb = 0;
    if (m) begin
      if (!m_valid[idx][0])      v = 0;
      else if (!m_valid[idx][1]) v = 1;
      else                       v = m_lru[idx];
      wb = m_valid[idx][v] && m_dirty[idx][v];
    end
    xfers = !m ? 0 : (wb ? 2 : 1);

    @(posedge clk); #1;
    cpu_req = 1; cpu_index = IW'(idx); cpu_we = we; miss = m; way_f = wf;
    @(negedge clk);
    checks++;
    if ({cpu_ready, busy, wb_req, refill_req, array_we, tag_we} !== {4'b0, !m && we, 1'b0}) begin
      errors++;
      $display("FAIL %s accept: rdy/busy/wb/rf/awe/twe=%b expected %b", nm,
               {cpu_ready, busy, wb_req, refill_req, array_we, tag_we}, {4'b0, !m && we, 1'b0});
    end
    if (!m) begin
      checks++;
      if (act_way !== wf) begin
        errors++;
        $display("FAIL %s hit_way: act_way=%b expected %b", nm, act_way, wf);
      end
    end
    @(posedge clk); #1;

    for (int ph = 0; ph < xfers; ph++) begin
      is_rf = (xfers == 1) || (ph == 1);
      for (int b = 0; b < BEATS; b++) begin
        eb = BW'(b);
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            mem_ack = 0; cpu_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({cpu_ready, wb_req, refill_req, array_we, tag_we, act_way, beat_idx} !==
                {1'b0, !is_rf, is_rf, 1'b0, 1'b0, v, eb}) begin
              errors++;
              $display("FAIL %s gap ph%0d b%0d: rdy/wb/rf/awe/twe/way/beat=%b expected %b", nm, ph, b,
                       {cpu_ready, wb_req, refill_req, array_we, tag_we, act_way, beat_idx},
                       {1'b0, !is_rf, is_rf, 1'b0, 1'b0, v, eb});
            end
            @(posedge clk); #1;
          end
        end
        mem_ack = 1;
        @(negedge clk);
        checks++;
        if ({cpu_ready, wb_req, refill_req, array_we, tag_we, act_way, beat_idx} !==
            {1'b0, !is_rf, is_rf, is_rf, is_rf && (b == BEATS - 1), v, eb}) begin
          errors++;
          $display("FAIL %s ack ph%0d b%0d: rdy/wb/rf/awe/twe/way/beat=%b expected %b", nm, ph, b,
                   {cpu_ready, wb_req, refill_req, array_we, tag_we, act_way, beat_idx},
                   {1'b0, !is_rf, is_rf, is_rf, is_rf && (b == BEATS - 1), v, eb});
        end
        @(posedge clk); #1;
        mem_ack = 0;
      end
    end

    // Response cycle; a stray ack here must be ignored.
    cpu_req = 1;
    mem_ack = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_ready, busy, wb_req, refill_req, array_we, tag_we} !== 6'b110000) begin
      errors++;
      $display("FAIL %s respond: rdy/busy/wb/rf/awe/twe=%b expected 110000", nm,
               {cpu_ready, busy, wb_req, refill_req, array_we, tag_we});
    end
    @(posedge clk); #1;
    cpu_req = 0; mem_ack = 0;
    @(negedge clk);
    checks++;
    if ({cpu_ready, busy, beat_idx} !== {2'b00, BW'(0)}) begin
      errors++;
      $display("FAIL %s done: rdy/busy/beat=%b expected 0", nm, {cpu_ready, busy, beat_idx});
    end

    if (!m) begin
      m_lru[idx] = !wf;
      if (we) m_dirty[idx][wf] = 1;
    end else begin
      m_valid[idx][v] = 1;
      m_dirty[idx][v] = we;
      m_lru[idx]      = !v;
    end
  endtask

  task automatic test_reset();
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_index = '0; miss = 0; way_f = 0; mem_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_ready, busy, wb_req, refill_req, beat_idx, act_way, array_we, tag_we} !== '0) begin
      errors++;
      $display("FAIL reset: outputs=%b expected 0",
               {cpu_ready, busy, wb_req, refill_req, beat_idx, act_way, array_we, tag_we});
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_refill_cold();
    access(3, 0, 1, 0, 0, "cold_miss_way0");
    access(3, 0, 1, 0, 0, "cold_miss_way1");
  endtask

  task automatic test_store_hit();
    access(3, 1, 0, 0, 0, "store_hit");
  endtask

  task automatic test_writeback();
    access(3, 0, 0, 1, 0, "load_hit_w1");
    if (!(m_valid[3][0] && m_dirty[3][0] && m_lru[3] == 0)) begin
      errors++;
      $display("FAIL wb_setup: model not primed for dirty eviction");
    end
    access(3, 0, 1, 0, 0, "dirty_evict");
    checks++;
    if (m_dirty[3][0] !== 1'b0) begin
      errors++;
      $display("FAIL wb_clean: dirty[3][0]=%b expected 0", m_dirty[3][0]);
    end
  endtask

  task automatic test_reset_mid_refill();
    @(posedge clk); #1;
    cpu_req = 1; cpu_index = 3; cpu_we = 0; miss = 1; way_f = 0;
    @(posedge clk); #1;
    if (m_valid[3][m_lru[3]] && m_dirty[3][m_lru[3]]) begin
      repeat (BEATS) begin
        mem_ack = 1; @(posedge clk); #1;
      end
    end
    repeat (2) begin
      mem_ack = 1; @(posedge clk); #1;
    end
    // Still in REFILL with an ack present when reset arrives.
    cpu_req = 0; rst = 1; mem_ack = 1;
    @(negedge clk);
    checks++;
    if ({array_we, tag_we} !== 2'b00) begin
      errors++;
      $display("FAIL rst_strobe: array_we/tag_we=%b expected 00", {array_we, tag_we});
    end
    @(posedge clk); #1;
    rst = 0; mem_ack = 0;
    @(negedge clk);
    checks++;
    if ({cpu_ready, busy, wb_req, refill_req, beat_idx, act_way, array_we, tag_we} !== '0) begin
      errors++;
      $display("FAIL rst_abort: outputs=%b expected 0",
               {cpu_ready, busy, wb_req, refill_req, beat_idx, act_way, array_we, tag_we});
    end
    model_clear();
    access(3, 0, 1, 0, 0, "post_rst_miss");
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_ack = 1'(i % 2 == 0);
      @(negedge clk);
      checks++;
      if ({busy, wb_req, refill_req, array_we, tag_we, beat_idx} !== '0) begin
        errors++;
        $display("FAIL idle_ack %0d: busy/wb/rf/awe/twe/beat=%b expected 0", i,
                 {busy, wb_req, refill_req, array_we, tag_we, beat_idx});
      end
    end
    @(posedge clk); #1;
    mem_ack = 0;
    access(9, 0, 1, 1, 1, "gap_refill");
  endtask

  task automatic test_back_to_back();
    access(7, 1, 1, 0, 0, "b2b_store_miss");
    access(7, 0, 1, 0, 0, "b2b_fill_w1");
    access(7, 0, 0, 0, 0, "b2b_hit_w0");
    access(7, 0, 1, 0, 0, "b2b_miss_lru");
    access(7, 1, 0, 1, 0, "b2b_store_w1");
    access(7, 0, 1, 0, 0, "b2b_miss_wb");
  endtask

  task automatic test_random();
    int idx;
    bit we, m, wf;
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 3);
      we  = 1'($urandom_range(0, 1));
      wf  = 1'($urandom_range(0, 1));
      m   = ($urandom_range(0, 2) == 0) || !m_valid[idx][wf];
      access(idx, we, m, wf, 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_refill_cold();
    test_store_hit();
    test_writeback();
    test_reset_mid_refill();
    test_idle_ack();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
Sequential control stage that sits directly downstream of the 2-way cache hit encoder and consumes its Miss and found-way outputs. It holds per-set valid, dirty and LRU state. It selects a victim way on a miss and runs a beat-counted writeback and refill handshake with memory. It then drives the data/tag array write strobes and the CPU ready response.

Parameters:
INDEX_W, 4, set index width; number of sets is 2**INDEX_W.
BEATS, 4, words per line, transferred one per mem_ack; must be a power of two, at least 2.
BEAT_W, 2, width of the beat counter; equals log2(BEATS).

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  synchronous, active-high reset.
cpu_req  in  1  CPU access request; held until cpu_ready.
cpu_we  in  1  1 = store, 0 = load.
cpu_index  in  INDEX_W  set index of the request.
miss  in  1  from hit encoder: 1 = neither way hit.
way_f  in  1  from hit encoder: hitting way; valid only when miss = 0.
cpu_ready  out  1  one-cycle completion pulse.
busy  out  1  high in any state other than IDLE.
wb_req  out  1  writeback request to memory; high throughout WRITEBACK.
refill_req  out  1  line fetch request to memory; high throughout REFILL.
mem_ack  in  1  one pulse per transferred beat.
beat_idx  out  BEAT_W  current beat number within the line.
act_way  out  1  way being read, written back or refilled.
array_we  out  1  data array word write strobe.
tag_we  out  1  tag write strobe for act_way at the latched index.

Behaviour:
Reset (rst = 1 at a clk edge):
- All valid, dirty and LRU bits are cleared.
- State goes to IDLE and the beat counter goes to 0.
- All outputs are 0: cpu_ready, busy, wb_req, refill_req, beat_idx, act_way, array_we, tag_we.
- Reset applied mid-WRITEBACK or mid-REFILL aborts the transfer; no strobe is issued in the reset cycle.

State machine: IDLE, WRITEBACK, REFILL, RESPOND.
- IDLE: on cpu_req = 1, latch cpu_index, cpu_we, miss and way_f. miss and way_f are sampled only in IDLE.
- Hit (miss = 0):
  - Set LRU[idx] = ~way_f.
  - If cpu_we = 1, set dirty[idx][way_f] = 1 and pulse array_we with act_way = way_f in the same cycle.
  - Go to RESPOND.
- Miss, victim selection:
  - If valid[idx][0] = 0, the victim is way 0.
  - Else if valid[idx][1] = 0, the victim is way 1.
  - Else the victim is LRU[idx].
  - The victim is latched into act_way.
- Miss, next state: if the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL. The beat counter is cleared either way.
- WRITEBACK:
  - wb_req = 1.
  - Each mem_ack increments beat_idx.
  - The ack with beat_idx = BEATS-1 clears the counter and moves to REFILL.
- REFILL:
  - refill_req = 1.
  - Each mem_ack pulses array_we in the same cycle (combinational from mem_ack), with act_way and the current beat_idx, then increments beat_idx.
  - On the last beat, tag_we also pulses.
  - On the next edge after the last beat: valid[idx][act_way] = 1, dirty[idx][act_way] = cpu_we, LRU[idx] = ~act_way, go to RESPOND.
  - For a store miss, the CPU word is merged by the datapath on the final array write.
- RESPOND: cpu_ready = 1 for exactly one cycle, then return to IDLE.

Timing:
- Hit latency: request accepted at edge N, cpu_ready high in cycle N+1.
- Miss latency: 1 + (number of transfers × BEATS ack cycles) + 1 cycle.

Boundaries:
- mem_ack is ignored in IDLE and RESPOND.
- cpu_req is ignored outside IDLE; the CPU holds it until cpu_ready.
- A new request is accepted no earlier than the cycle after cpu_ready.
- beat_idx wraps to 0 after BEATS-1.
- A back-to-back hit and miss to the same set sees the updated LRU.
- The dirty bit of a non-victim way is never modified on a miss.

Test Plan:
- Reset then load to idx 3 with miss = 1 → victim way 0, no writeback, refill_req high, 4 mem_acks give array_we with beat_idx 0,1,2,3, tag_we on beat 3. One cycle later cpu_ready = 1. valid[3][0] = 1, LRU[3] = 1.
- Load miss again to idx 3 → way 0 valid, way 1 invalid, so the victim is way 1. After refill both ways are valid and LRU[3] = 0.
- Store hit to idx 3 with way_f = 0 → array_we and act_way = 0 in the accept cycle, cpu_ready next cycle, dirty[3][0] = 1, LRU[3] = 1.
- Load hit to idx 3 with way_f = 1 makes LRU[3] = 0; the next miss evicts dirty way 0 → WRITEBACK with 4 acks and wb_req high, then REFILL with 4 acks. After completion dirty[3][0] = 0 and cpu_ready pulses once.
- Assert rst after the 2nd REFILL ack → next cycle all outputs are 0 and state is IDLE. A subsequent miss to idx 3 picks way 0 again, because valid bits were cleared.
- mem_ack pulses in IDLE and cpu_req toggling during REFILL → no array_we, no state change, beat count unaffected.
